// File: rtl/arb_requester_if.sv
// arb_requester_if: job intake, request/grant and beat signals of arb_requester.
//   master : job source and grant source (arbiter side / testbench)
//   slave  : arb_requester
//   job_valid/job_ch/job_len -> job_ready   job offer handshake
//   REQ -> arbiter, GNT <- arbiter          4 channels, GNT registered one-hot
//   beat_valid/beat_ch/beat_last            beat transferred this cycle
//   busy, err                               per-channel outstanding, sticky errors
interface arb_requester_if;
  logic       job_valid;
  logic [1:0] job_ch;
  logic [3:0] job_len;
  logic       job_ready;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic       beat_valid;
  logic [1:0] beat_ch;
  logic       beat_last;
  logic [3:0] busy;
  logic [1:0] err;

  modport master (
    output job_valid, job_ch, job_len, GNT,
    input  job_ready, REQ, beat_valid, beat_ch, beat_last, busy, err
  );

  modport slave (
    input  job_valid, job_ch, job_len, GNT,
    output job_ready, REQ, beat_valid, beat_ch, beat_last, busy, err
  );
endinterface

// File: rtl/arb_requester.sv
// arb_requester: accepts jobs (channel + beat count) for 4 channels, raises a
// request line per pending channel towards a round-robin arbiter and counts
// down beats as grants come back.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : arb_requester_if.slave (job handshake, REQ/GNT, beat, busy, err)
// Optional build macro GRANT_CHECK_EN adds sticky grant checkers on err:
//   err[0] multi-grant seen, err[1] grant to a channel not requesting.
// Without it err is tied to 00 and no checker state exists.

// Per-channel remaining-beat counter. rem=0 is IDLE, rem>0 is PEND.
module arb_req_chan (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_len,
  input  logic       i_beat,
  input  logic       i_gnt,
  output logic       o_idle,
  output logic       o_last,
  output logic       o_req
);
  logic [3:0] r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_rem <= 4'd0;
    else if (i_load)               r_rem <= i_len;
    else if (i_beat && !o_idle)    r_rem <= r_rem - 4'd1;
  end

  assign o_idle = (r_rem == 4'd0);
  assign o_last = (r_rem == 4'd1);
  // Drop the request while the last beat is being granted so the registered
  // arbiter never issues a grant to an already-finished channel.
  assign o_req  = !o_idle && !(o_last && i_gnt);
endmodule

module arb_requester (
  input  logic           clk,
  input  logic           rst,
  arb_requester_if.slave bus
);
  localparam int NUM_CH = 4;

  logic [NUM_CH-1:0] w_idle, w_last, w_req, w_beat, w_load;
  logic              w_onehot, w_accept;
  logic [1:0]        w_beat_ch;

  // Multi-grant disables all beats; zero grant is simply idle.
  assign w_onehot = (bus.GNT != 4'd0) && ((bus.GNT & (bus.GNT - 4'd1)) == 4'd0);

  // Loads only target IDLE channels and beats only PEND ones, so a channel
  // can never load and count in the same cycle; a channel doing its last
  // beat is still PEND, which blocks re-acceptance until the next cycle.
  assign w_accept      = bus.job_valid && w_idle[bus.job_ch];
  assign bus.job_ready = w_accept;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_beat[g] = w_onehot && bus.GNT[g] && !w_idle[g];
    assign w_load[g] = w_accept && (bus.job_ch == 2'(g)) && (bus.job_len != 4'd0);

    arb_req_chan u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load[g]),
      .i_len  (bus.job_len),
      .i_beat (w_beat[g]),
      .i_gnt  (bus.GNT[g]),
      .o_idle (w_idle[g]),
      .o_last (w_last[g]),
      .o_req  (w_req[g])
    );
  end

  always_comb begin
    w_beat_ch = 2'd0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_beat[i]) w_beat_ch = 2'(i);
  end

  assign bus.REQ        = w_req;
  assign bus.busy       = ~w_idle;
  assign bus.beat_valid = |w_beat;
  assign bus.beat_ch    = w_beat_ch;
  assign bus.beat_last  = |(w_beat & w_last);

`ifdef GRANT_CHECK_EN
  logic [1:0]        r_err;
  logic [NUM_CH-1:0] r_req_d;   // REQ of the previous cycle

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err   <= 2'b00;
      r_req_d <= '0;
    end else begin
      r_req_d <= w_req;
      if ((bus.GNT != 4'd0) && !w_onehot) r_err[0] <= 1'b1;
      if (|(bus.GNT & ~r_req_d))          r_err[1] <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 2'b00;
`endif
endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 The module SHALL be clocked by clk, with reset rst, asynchronous, active-low.
REQ-002 Ports SHALL be exactly:
  clk  input  1  clock, rising edge
  rst  input  1  asynchronous active-low reset
  job_valid  input  1  job offered this cycle
  job_ch  input  2  target channel of offered job
  job_len  input  4  beats requested, 1..15; 0 = null job
  job_ready  output  1  offered job accepted this cycle
  REQ  output  4  one request line per channel, to round-robin arbiter
  GNT  input  4  registered one-hot grant from arbiter, 0 = no grant
  beat_valid  output  1  one beat transferred this cycle
  beat_ch  output  2  channel owning current beat
  beat_last  output  1  current beat is final beat of its job
  busy  output  4  per-channel job outstanding
  err  output  2  [0] multi-grant sticky, [1] spurious-grant sticky

Function
REQ-003 Each channel i SHALL hold a 4-bit remaining-beat counter rem_i; per-channel state IDLE (rem_i=0) or PEND (rem_i>0); busy[i] = PEND.
REQ-004 job_ready SHALL be combinational: job_valid AND channel job_ch is IDLE.
REQ-005 On a clock edge with job_ready=1 and job_len/=0, rem_(job_ch) SHALL load job_len (IDLE->PEND); job_len=0 SHALL be accepted and discarded with no state change.
REQ-006 REQ[i] SHALL be combinational: rem_i/=0 AND NOT (rem_i=1 AND GNT[i]=1), so request drops during the last granted beat and the arbiter never grants a finished channel.
REQ-007 A beat SHALL occur on channel i in any cycle with GNT[i]=1 and rem_i/=0; beat_valid=1, beat_ch=i, beat_last=(rem_i=1), all combinational from the same cycle.
REQ-008 On each beat edge rem_i SHALL decrement by 1; at 1->0 the channel SHALL return to IDLE.
REQ-009 At most one channel SHALL decrement per cycle; if GNT has >1 bit set, beat_valid SHALL be 0 and no counter changes.
REQ-010 GNT[i]=1 with rem_i=0 (spurious) SHALL be ignored: no beat, no counter change.
REQ-011 A job for channel i SHALL NOT be accepted in the cycle channel i performs its last beat; job_ready SHALL assert no earlier than the following cycle.
REQ-012 A job for channel j SHALL be accepted in the same cycle as a beat on channel i/=j, both taking effect at that edge.
REQ-013 Minimum latency: job accepted at edge T -> REQ high in cycle T+1 -> first possible beat in cycle T+2 (arbiter's registered grant).
REQ-014 A channel SHALL be granted at most job_len beats per job; counters SHALL never wrap below 0.

Reset
REQ-015 While rst=0, all rem_i SHALL be 0, err=00, and hence REQ=0000, busy=0000, beat_valid=0, beat_ch=00, beat_last=0, job_ready=0 only if job_valid=0.
REQ-016 Reset asserted mid-job SHALL abort all outstanding jobs immediately with no beat_last or completion indication.

Configuration
REQ-017 Macro GRANT_CHECK_EN: when defined, err[0] SHALL set on any cycle with GNT not zero/one-hot and err[1] SHALL set on any cycle with GNT[i]=1 and REQ[i] low on the previous cycle, both sticky until reset.
REQ-018 Without GRANT_CHECK_EN, err SHALL be constant 00 and no checker registers SHALL exist; REQ-009/REQ-010 behaviour SHALL remain.

Verification
REQ-019 Single job ch0 len=3 with arbiter attached -> REQ=0001 from T+1, GNT=0001 three cycles, beat_last on third, REQ=0000 during third beat, arbiter returns to idle, err=00.
REQ-020 Jobs ch1 len=2 and ch3 len=2 on consecutive cycles -> beats rotate 1,3,1,3; beat_last on the second beat of each; busy=0000 afterwards.
REQ-021 Forced GNT=0101 with ch0 and ch2 PEND -> beat_valid=0, counters unchanged, err[0]=1 (GRANT_CHECK_EN) or err=00 (without).
REQ-022 Forced GNT=0100 with ch2 IDLE -> no beat, busy unchanged, err[1]=1 under GRANT_CHECK_EN.
REQ-023 job_valid for ch0 during ch0's last beat -> job_ready=0; re-offered next cycle -> job_ready=1 and accepted; job_len=0 -> job_ready=1, busy stays 0.
REQ-024 rst pulled low during ch2 len=15 job after 4 beats -> REQ=0000, busy=0000, err=00 asynchronously; no further beats after release.
